// File: rtl/loader_pkg.sv
// Shared types for the instruction-memory program loader: FSM states and the NOP fill word.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        DONE,
        ERR
    } state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/program_loader.sv
// Program loader: NOP-fills IMEM, then streams a program into it and releases the core.
// Latency: memory write port is registered, one cycle after the issuing CLEAR step or transfer.
// Backpressure: in_ready is high only in LOAD, one word accepted per cycle; ignored elsewhere.
module program_loader
    import loader_pkg::*;
#(
    parameter int IMEM_WORDS = 32,
    parameter int ADDR_W     = $clog2(IMEM_WORDS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_run,
    output logic              busy,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_WORDS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LAST_WC   = (ADDR_W + 1)'(IMEM_WORDS - 1);
    localparam logic [ADDR_W:0]   WC_ONE    = (ADDR_W + 1)'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic [ADDR_W:0]     word_count_q, word_count_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            clr_addr_q   <= '0;
            word_count_q <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            word_count_q <= word_count_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        word_count_d = word_count_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            CLEAR: begin
                we_d       = 1'b1;
                addr_d     = clr_addr_q;
                wdata_d    = NOP_INSTR;
                clr_addr_d = clr_addr_q + ADDR_ONE;
                // word_count keeps the previous program's length until the fill completes
                if (clr_addr_q == LAST_ADDR) begin
                    state_d      = LOAD;
                    word_count_d = '0;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    we_d         = 1'b1;
                    addr_d       = word_count_q[ADDR_W-1:0];
                    wdata_d      = in_data;
                    word_count_d = word_count_q + WC_ONE;
                    // in_last wins over overflow: a program that exactly fills memory is legal
                    if (in_last) begin
                        state_d = DONE;
                    end else if (word_count_q == LAST_WC) begin
                        state_d = ERR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready   = (state_q == LOAD);
    assign busy       = (state_q == CLEAR) || (state_q == LOAD);
    assign core_run   = (state_q == DONE);
    assign error      = (state_q == ERR);
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader against a transaction-level model of the loader's rules.
module tb_program_loader;

    localparam int          W   = 32;
    localparam int          AW  = 5;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clock = 1'b0;
    logic          reset, start, in_valid, in_last;
    logic [31:0]   in_data;
    logic          in_ready, imem_we, core_run, busy, error;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   word_count;

    program_loader #(.IMEM_WORDS(W)) dut (
        .clock(clock), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_run(core_run), .busy(busy), .error(error), .word_count(word_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 filling, 2 accepting, 3 program ready, 4 overflowed
    int          m_mode;
    int          m_fill_left;
    int          m_wc;
    bit          m_we;
    bit          m_rst;
    bit          model_ok = 1'b0;
    int          m_addr;
    logic [31:0] m_wdata;
    logic [31:0] mem_ref [W];
    logic [31:0] tb_mem  [W];

    always @(posedge clock) begin
        m_rst = 1'b0;
        if (!reset) begin
            m_mode = 0; m_wc = 0; m_we = 1'b0; m_addr = 0; m_wdata = '0;
            m_fill_left = 0; m_rst = 1'b1; model_ok = 1'b1;
        end else begin
            m_we = 1'b0;
            case (m_mode)
                0, 3, 4: if (start) begin
                    m_mode = 1;
                    m_fill_left = W;
                end
                1: begin
                    m_we = 1'b1; m_addr = W - m_fill_left; m_wdata = NOP;
                    mem_ref[m_addr] = NOP;
                    m_fill_left--;
                    if (m_fill_left == 0) begin
                        m_mode = 2;
                        m_wc = 0;
                    end
                end
                2: if (in_valid) begin
                    m_we = 1'b1; m_addr = m_wc; m_wdata = in_data;
                    mem_ref[m_wc] = in_data;
                    m_wc++;
                    if (in_last) m_mode = 3;
                    else if (m_wc == W) m_mode = 4;
                end
                default: m_mode = 0;
            endcase
        end
    end

    always @(negedge clock) begin
        if (model_ok) begin
            chk("core_run", core_run, m_mode == 3);
            chk("busy", busy, (m_mode == 1) || (m_mode == 2));
            chk("error", error, m_mode == 4);
            chk("in_ready", in_ready, m_mode == 2);
            chk("imem_we", imem_we, m_we);
            if (m_we || m_rst) begin
                chk("imem_addr", imem_addr, m_addr);
                chk("imem_wdata", imem_wdata, m_wdata);
            end
            if (m_mode != 1) chk("word_count", word_count, m_wc);
        end
        if (imem_we === 1'b1) tb_mem[imem_addr] = imem_wdata;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: in_ready never rose within %0d cycles", n);
        end
    endtask

    task automatic send(input logic [31:0] d, input bit last);
        wait_ready();
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic load_prog(input int len, input bit with_last);
        for (int i = 0; i < len; i++) begin
            send($urandom, with_last && (i == len - 1));
            if (i != len - 1) repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic check_mem(input string nm);
        for (int i = 0; i < W; i++) chk(nm, tb_mem[i], mem_ref[i]);
    endtask

    initial begin
        reset = 1'b0; start = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        repeat (2) tick();
        chk("rst_busy", busy, 0);
        chk("rst_run", core_run, 0);
        chk("rst_wc", word_count, 0);
        reset = 1'b1; start = 1'b0;
        tick();

        // Fill length: in_ready rises exactly IMEM_WORDS cycles after CLEAR is entered
        pulse_start();
        chk("clr_busy", busy, 1);
        repeat (W - 1) tick();
        chk("clr_not_ready", in_ready, 0);
        tick();
        chk("clr_ready", in_ready, 1);
        sample();
        chk("clr_mem0", tb_mem[0], NOP);
        chk("clr_mem31", tb_mem[31], NOP);

        // Three-word program with gaps
        send(32'h0050_0093, 1'b0);
        repeat (2) tick();
        send(32'h00A0_0113, 1'b0);
        tick();
        send(32'h0020_81B3, 1'b1);
        sample();
        chk("p3_run", core_run, 1);
        chk("p3_wc", word_count, 3);
        chk("p3_mem0", tb_mem[0], 32'h0050_0093);
        chk("p3_mem1", tb_mem[1], 32'h00A0_0113);
        chk("p3_mem2", tb_mem[2], 32'h0020_81B3);
        chk("p3_mem3", tb_mem[3], NOP);

        // Restart from DONE, then exact fill
        pulse_start();
        chk("restart_run_drop", core_run, 0);
        chk("restart_busy", busy, 1);
        load_prog(W, 1'b1);
        sample();
        chk("full_err", error, 0);
        chk("full_run", core_run, 1);
        chk("full_wc", word_count, 32);
        check_mem("full_mem");

        // Overflow, then extra in_valid must not write
        pulse_start();
        load_prog(W, 1'b0);
        sample();
        chk("ovf_err", error, 1);
        chk("ovf_run", core_run, 0);
        chk("ovf_ready", in_ready, 0);
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        repeat (3) tick();
        in_valid = 1'b0;
        chk("ovf_no_write", imem_we, 0);
        check_mem("ovf_mem");

        // Restart from ERR, reset mid-load at word 5
        pulse_start();
        chk("err_clear", error, 0);
        load_prog(5, 1'b0);
        wait_ready();
        in_valid = 1'b1; reset = 1'b0;
        tick();
        in_valid = 1'b0; reset = 1'b1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wc", word_count, 0);
        chk("mid_rst_run", core_run, 0);
        tick();

        // Randomized programs with ignored start / in_valid noise
        for (int it = 0; it < 8; it++) begin
            bit lst;
            int len;
            lst = ($urandom_range(0, 3) != 0);
            len = lst ? $urandom_range(1, W) : W;
            pulse_start();
            repeat ($urandom_range(0, 5)) tick();
            start = 1'b1; in_valid = 1'b1; in_data = $urandom;
            tick();
            start = 1'b0; in_valid = 1'b0;
            load_prog(len, lst);
            in_valid = 1'b1; in_data = $urandom;
            repeat (2) tick();
            in_valid = 1'b0;
            sample();
            check_mem("rnd_mem");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Upstream companion of the RISC-V `Datapath`. It receives a stream of 32-bit instruction words over a valid/ready handshake and NOP-fills the instruction memory through its write port. It then writes the program from word 0 upward. It holds the core in reset until a complete program is present, then releases it via `core_run`.

## Interface
Parameters:
- `IMEM_WORDS`, 32: instruction memory depth in words; power of two, ≥ 2.
- `ADDR_W`, $clog2(IMEM_WORDS): word-address width.

Ports:
- `clock`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  single-cycle load request.
- `in_valid`  in  1  producer has a word on `in_data`.
- `in_ready`  out  1  loader accepts a word this cycle.
- `in_data`  in  32  instruction word.
- `in_last`  in  1  qualifies the final word of the program.
- `imem_we`  out  1  instruction memory write enable.
- `imem_addr`  out  ADDR_W  word address (byte address = `imem_addr`<<2).
- `imem_wdata`  out  32  write data.
- `core_run`  out  1  high means the datapath runs; low means the datapath is held in reset (drives the core's reset).
- `busy`  out  1  high in CLEAR or LOAD.
- `error`  out  1  overflow; sticky until next `start` or reset.
- `word_count`  out  ADDR_W+1  words of the current program accepted so far.

## Operation
States:
- **IDLE**
  - `start` → CLEAR.
  - Reset exit state: core not running.
- **CLEAR**
  - Walks addr 0..IMEM_WORDS-1, one write per cycle, data `NOP` (32'h00000013).
  - After addr IMEM_WORDS-1 is issued → LOAD; `word_count` is cleared to 0.
- **LOAD**
  - `in_ready`=1. A transfer happens when `in_valid && in_ready`.
  - Each transfer writes `in_data` to addr `word_count`, then `word_count`++.
  - Transfer with `in_last`=1 → DONE.
  - Transfer at addr IMEM_WORDS-1 with `in_last`=0 → ERR. That word is still written.
- **DONE**
  - `core_run`=1. `start` → CLEAR, and `core_run` drops.
- **ERR**
  - `error`=1, `core_run`=0. `start` → CLEAR and clears `error`.

General rules:
- `start` is ignored in CLEAR and LOAD.
- `in_ready`=0 in all states except LOAD; `in_valid` outside LOAD is ignored, and no data is lost or written.
- `in_last` on the first word is legal: a one-word program, `word_count`=1.
- `in_last` on word IMEM_WORDS-1 is legal: the memory is exactly full → DONE, no error.
- `in_data` is not interpreted.

## Timing
- Reset (`reset`=0 at an edge): state IDLE, `core_run`=0, `busy`=0, `error`=0, `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `word_count`=0. Memory contents are unspecified after a mid-load reset.
- `imem_we`/`imem_addr`/`imem_wdata` are registered: a write appears exactly one cycle after the cycle that issues it (CLEAR step or accepted transfer).
- `start` sampled at edge N (IDLE):
  - state=CLEAR, `busy`=1 from N+1.
  - First NOP write is visible (`imem_we`=1, addr 0) at N+2.
  - CLEAR occupies IMEM_WORDS cycles.
- LOAD: `in_ready` is high in every cycle of LOAD; throughput is one word per cycle.
- `core_run` rises the cycle after the `in_last` transfer, coincident with the final program write on the memory port. The memory is synchronous-write, so the core's first fetch at the next edge sees the complete program.
- `core_run` falls the cycle after `start` is sampled in DONE.

## Structure
- Package `loader_pkg`: state enum {IDLE, CLEAR, LOAD, DONE, ERR} and constant `NOP_INSTR` = 32'h00000013.
- Single module with FSM, address/word counter and registered write port; no sub-module.
- The top level instantiates `program_loader` beside `Datapath`, muxing the instruction-memory write port to the loader.

## Test plan
- Reset: hold `reset`=0 for 2 cycles → all outputs 0, state IDLE; `start`=1 while `reset`=0 → stays IDLE.
- Clear: IMEM_WORDS=32, pulse `start` → 32 writes, addr 0..31, data 32'h00000013, `busy`=1 throughout; then `in_ready`=1.
- Three-word load:
  - Stimulus: 32'h00500093, 32'h00A00113, 32'h002081B3, `in_last` on the third, with `in_valid` gaps between words.
  - Required: writes to addr 0,1,2 with those values; `word_count`=3; `core_run`=1 one cycle after the third transfer.
- Exact fill: 32 words, `in_last` on word 31 → DONE, `error`=0.
- Overflow: 32 words, none with `in_last` → word 31 written, then `error`=1, `core_run`=0, `in_ready`=0; a 33rd `in_valid` → no write.
- Restart and mid-load reset:
  - `start` in DONE → `core_run`=0 next cycle and the CLEAR sequence repeats.
  - `reset`=0 during LOAD at word 5 → IDLE next cycle, `word_count`=0, `core_run`=0.
